// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - latches a 32-bit word and scans it as 8 hex digits on a common-anode display
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic        upper_lower,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [15:0] led
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    digit;
    logic [31:0]   shadow;
    logic          ul_q;
    logic          tick;
    logic [3:0]    nibble;
    logic [2:0]    msd;
    logic          blanked;
    logic [6:0]    seg_next;
    logic [7:0]    an_next;
    logic          dp_next;

    assign tick   = (prescaler == LAST);
    assign nibble = 4'(shadow >> {digit, 2'b00});

    // Highest non-zero nibble; stays 0 for an all-zero word so digit 0 is always lit.
    always_comb begin
        msd = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (shadow[4*k +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
    end

    assign blanked = BLANK_EN && blank_lz && (digit > msd);

    always_comb begin
        seg_next = 7'h7F;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'h7F;
        endcase
        if (blanked) begin
            seg_next = 7'h7F;
        end
    end

    assign an_next = blanked ? 8'hFF : ~(8'b1 << digit);
    assign dp_next = blanked || !((digit == 3'd4) && ul_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= 32'h0;
            ul_q      <= 1'b0;
            led       <= 16'h0;
            prescaler <= '0;
            digit     <= 3'd0;
            an_n      <= 8'hFF;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
        end else begin
            if (load) begin
                shadow <= data_in;
                ul_q   <= upper_lower;
                led    <= upper_lower ? data_in[31:16] : data_in[15:0];
            end
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                digit <= digit + 3'd1;
            end
            an_n  <= an_next;
            seg_n <= seg_next;
            dp_n  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        upper_lower = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .upper_lower(upper_lower), .blank_lz(blank_lz),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .led(led)
    );

    always #5 clk = ~clk;

    // Reference model: word/flag/led plus the number of edges since reset release.
    logic [31:0] m_sh;
    logic        m_ul;
    logic [15:0] m_led;
    int          m_n;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    function automatic logic [6:0] hex_seg(input int v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [31:0] d,
                        input logic u, input logic b);
        int dg, msd, nib;
        bit blk;
        reset = r; load = ld; data_in = d; upper_lower = u; blank_lz = b;
        @(posedge clk);
        if (r) begin
            m_sh = 0; m_ul = 0; m_led = 0; m_n = 0;
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            dg  = (m_n / 4) % 8;
            msd = 0;
            for (int k = 0; k < 8; k++) if (((m_sh >> (4 * k)) & 32'hF) != 0) msd = k;
            nib = int'((m_sh >> (4 * dg)) & 32'hF);
            blk = b && (dg > msd);
            m_an  = blk ? 8'hFF : 8'(~(1 << dg));
            m_seg = blk ? 7'h7F : hex_seg(nib);
            m_dp  = (!blk && dg == 4 && m_ul) ? 1'b0 : 1'b1;
            if (ld) begin
                m_sh = d; m_ul = u;
                m_led = u ? d[31:16] : d[15:0];
            end
            m_n++;
        end
        #1;
        chk("model_an_n", {24'h0, an_n}, {24'h0, m_an});
        chk("model_seg_n", {25'h0, seg_n}, {25'h0, m_seg});
        chk("model_dp_n", {31'h0, dp_n}, {31'h0, m_dp});
        chk("model_led", {16'h0, led}, {16'h0, m_led});
    endtask

    typedef struct {
        logic        r, ld;
        logic [31:0] d;
        logic        u, b;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] led;
    } vec_t;

    vec_t vt [12];
    int   lit;

    initial begin
        for (int i = 0; i < 3; i++) vt[i] = '{1, 0, 0, 0, 0, 8'hFF, 7'h7F, 1, 16'h0};
        for (int i = 3; i < 7; i++) vt[i] = '{0, 0, 0, 0, 0, 8'hFE, 7'h40, 1, 16'h0};
        vt[7] = '{0, 1, 32'hE59F11F8, 0, 0, 8'hFD, 7'h40, 1, 16'h11F8};
        for (int i = 8; i < 11; i++) vt[i] = '{0, 0, 0, 0, 0, 8'hFD, 7'h0E, 1, 16'h11F8};
        vt[11] = '{0, 0, 0, 0, 0, 8'hFB, 7'h79, 1, 16'h11F8};

        for (int i = 0; i < 12; i++) begin
            step(vt[i].r, vt[i].ld, vt[i].d, vt[i].u, vt[i].b);
            chk("vec_an_n", {24'h0, an_n}, {24'h0, vt[i].an});
            chk("vec_seg_n", {25'h0, seg_n}, {25'h0, vt[i].seg});
            chk("vec_dp_n", {31'h0, dp_n}, {31'h0, vt[i].dp});
            chk("vec_led", {16'h0, led}, {16'h0, vt[i].led});
        end

        // upper half on LEDs and decimal point in the digit-4 slot
        step(0, 1, 32'hE59F11F8, 1, 0);
        chk("led_upper", {16'h0, led}, 32'hE59F);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0, 0);
            if (an_n == 8'hEF) chk("dp_digit4", {31'h0, dp_n}, 32'h0);
            else               chk("dp_other", {31'h0, dp_n}, 32'h1);
        end

        // leading-zero blanking
        step(0, 1, 32'h00000C04, 0, 1);
        for (int i = 0; i < 34; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 32'h0, 0, 1);
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 1);
            if (an_n != 8'hFF) begin
                lit++;
                chk("zero_lit_an", {24'h0, an_n}, 32'hFE);
                chk("zero_lit_seg", {25'h0, seg_n}, 32'h40);
            end
        end
        chk("zero_lit_cycles", lit, 4);

        // load coincident with the tick from digit 3 to digit 4
        for (int i = 0; i < 40 && (m_n % 32) != 15; i++) step(0, 0, 0, 0, 0);
        chk("align_tick", m_n % 32, 15);
        step(0, 1, 32'hABCD1234, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("coincident_an", {24'h0, an_n}, 32'hEF);
        chk("coincident_seg", {25'h0, seg_n}, 32'h21);

        // reset during the digit-5 slot
        for (int i = 0; i < 40 && ((m_n / 4) % 8) != 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 32'h12345678, 1, 0);
        chk("midreset_an", {24'h0, an_n}, 32'hFF);
        chk("midreset_led", {16'h0, led}, 32'h0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("restart_an", {24'h0, an_n}, 32'hFE);
        end
        step(0, 0, 0, 0, 0);
        chk("restart_next", {24'h0, an_n}, 32'hFD);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = $urandom & {{8{$urandom_range(0, 1) == 1}}, 24'hFFFFFF} & ($urandom_range(0, 3) == 0 ? 32'h0000FFFF : 32'hFFFFFFFF);
            step($urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0, d,
                 1'($urandom_range(0, 1)), (i / 100) % 2 == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
